// File: rtl/sha2uart_tx.sv
// Captures a digest on din_vld and transmits it as 8N1 UART frames, most-significant byte first.
// Frames are sent back to back with an internal baud divider of CLK_FREQ/BAUD clocks per bit.
module sha2uart_tx #(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned NUM_BYTES = 20
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [8*NUM_BYTES-1:0] din,
   input  logic                   din_vld,
   output logic                   busy,
   output logic                   uart_tx,
   output logic                   tx_done
);

   localparam int unsigned BaudDiv = CLK_FREQ / BAUD;
   localparam int unsigned CntW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
   localparam int unsigned ByteW   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int unsigned MsgW    = 8 * NUM_BYTES;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e           state_q, state_d;
   logic [MsgW-1:0]  msg_q, msg_d;
   logic [7:0]       shift_q, shift_d;
   logic [ByteW-1:0] byte_cnt_q, byte_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [CntW-1:0]  baud_cnt_q, baud_cnt_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             baud_tick, last_byte;

   assign baud_tick = (baud_cnt_q == CntW'(BaudDiv - 1));
   assign last_byte = (byte_cnt_q == ByteW'(NUM_BYTES - 1));

   always_comb begin
      state_d    = state_q;
      msg_d      = msg_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      baud_cnt_d = baud_cnt_q + 1'b1;
      tx_d       = tx_q;
      busy_d     = busy_q;
      tx_done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            baud_cnt_d = '0;
            if (din_vld) begin
               // msg_q holds only the bytes still to be loaded, left-aligned.
               msg_d      = din << 8;
               shift_d    = din[MsgW-1 -: 8];
               byte_cnt_d = '0;
               bit_cnt_d  = '0;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
               state_d    = StStart;
            end
         end
         StStart: begin
            if (baud_tick) begin
               baud_cnt_d = '0;
               tx_d       = shift_q[0];
               state_d    = StData;
            end
         end
         StData: begin
            if (baud_tick) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end
         end
         StStop: begin
            if (baud_tick) begin
               baud_cnt_d = '0;
               if (last_byte) begin
                  busy_d  = 1'b0;
                  tx_done = 1'b1;
                  state_d = StIdle;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  shift_d    = msg_q[MsgW-1 -: 8];
                  msg_d      = msg_q << 8;
                  bit_cnt_d  = '0;
                  tx_d       = 1'b0;
                  state_d    = StStart;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         msg_q      <= '0;
         shift_q    <= '0;
         byte_cnt_q <= '0;
         bit_cnt_q  <= '0;
         baud_cnt_q <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         msg_q      <= msg_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         baud_cnt_q <= baud_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign uart_tx = tx_q;

endmodule

// File: tb/tb_sha2uart_tx.sv
// Scoreboard bench for sha2uart_tx: a 2-byte/10-clock-bit instance and a 20-byte digest instance.
// The model tracks each message as an accept edge plus a fixed duration; UART receivers pop bytes.
module tb_sha2uart_tx;

   localparam int unsigned BdA = 10;  // 1000 / 100
   localparam int unsigned NbA = 2;
   localparam int unsigned BdB = 54;  // 50e6 / 921600, floored
   localparam int unsigned NbB = 20;

   logic         clk   = 1'b0;
   logic         rstn  = 1'b0;
   logic [15:0]  din_a = '0;
   logic [159:0] din_b = '0;
   logic         vld_a = 1'b0;
   logic         vld_b = 1'b0;
   wire  [1:0]   line, bsy, done;

   sha2uart_tx #(.CLK_FREQ(1000), .BAUD(100), .NUM_BYTES(NbA)) dut_a (
      .clk(clk), .rstn(rstn), .din(din_a), .din_vld(vld_a),
      .busy(bsy[0]), .uart_tx(line[0]), .tx_done(done[0])
   );

   sha2uart_tx #(.CLK_FREQ(50000000), .BAUD(921600), .NUM_BYTES(NbB)) dut_b (
      .clk(clk), .rstn(rstn), .din(din_b), .din_vld(vld_b),
      .busy(bsy[1]), .uart_tx(line[1]), .tx_done(done[1])
   );

   always #5 clk = ~clk;

   longint cyc = 0;  // posedges seen so far; read on negedges
   always @(posedge clk) cyc <= cyc + 1;

   int          checks = 0;
   int          errors = 0;
   int unsigned epoch  = 0;
   longint      p0   [2] = '{-100, -100};  // edge that accepted the current message
   longint      dend [2] = '{-100, -100};  // edge at which busy drops
   logic [7:0]  q_a [$];
   logic [7:0]  q_b [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int qsz(input int id);
      return (id == 0) ? q_a.size() : q_b.size();
   endfunction

   function automatic int unsigned bd_of(input int id);
      return (id == 0) ? BdA : BdB;
   endfunction

   function automatic int unsigned nb_of(input int id);
      return (id == 0) ? NbA : NbB;
   endfunction

   // Per-cycle check of busy/tx_done/idle line against the message windows.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("busy[%0d]", i), 64'(bsy[i]), 64'(cyc >= p0[i] && cyc < dend[i]));
         chk($sformatf("tx_done[%0d]", i), 64'(done[i]), 64'(cyc == dend[i] - 1));
         if (!(cyc >= p0[i] && cyc < dend[i]))
            chk($sformatf("idle_line[%0d]", i), 64'(line[i]), 64'd1);
         if (cyc == p0[i])
            chk($sformatf("start_edge[%0d]", i), 64'(line[i]), 64'd0);
      end
   end

   // Caller must be at a negedge; the strobe is sampled on the next posedge.
   task automatic strobe(input int id, input logic [159:0] val);
      longint s;
      s = cyc + 1;
      if (id == 0) begin
         din_a = val[15:0];
         vld_a = 1'b1;
      end else begin
         din_b = val;
         vld_b = 1'b1;
      end
      if (s > dend[id]) begin
         p0[id]   = s;
         dend[id] = s + longint'(nb_of(id)) * 10 * longint'(bd_of(id));
         for (int k = int'(nb_of(id)) - 1; k >= 0; k--) begin
            if (id == 0) q_a.push_back(val[8*k +: 8]);
            else         q_b.push_back(val[8*k +: 8]);
         end
      end
      @(negedge clk);
      vld_a = 1'b0;
      vld_b = 1'b0;
   endtask

   task automatic wait_idle(input int id, input int budget);
      int n = 0;
      while ((cyc < dend[id] || qsz(id) != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL wait_idle[%0d]: timeout after %0d cycles, %0d bytes undelivered",
                  id, budget, qsz(id));
      end
   endtask

   task automatic rx_loop(input int id);
      logic        prev, cur, sb;
      logic [7:0]  b, e;
      int unsigned ep;
      int unsigned bd;
      bd   = bd_of(id);
      prev = 1'b1;
      forever begin
         @(negedge clk);
         cur = line[id];
         if (rstn && prev && !cur) begin
            ep = epoch;
            repeat (bd / 2) @(negedge clk);
            sb = line[id];
            for (int k = 0; k < 8; k++) begin
               repeat (bd) @(negedge clk);
               b[k] = line[id];
            end
            repeat (bd) @(negedge clk);
            if (ep == epoch) begin
               chk($sformatf("start_bit[%0d]", id), 64'(sb), 64'd0);
               chk($sformatf("stop_bit[%0d]", id), 64'(line[id]), 64'd1);
               if (qsz(id) == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rx_unexpected[%0d]: got byte %0d, expected none", id, b);
               end else begin
                  e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                  chk($sformatf("rx_byte[%0d]", id), 64'(b), 64'(e));
               end
            end
            cur = line[id];
         end
         prev = cur;
      end
   endtask

   initial rx_loop(0);
   initial rx_loop(1);

   task automatic do_reset();
      rstn = 1'b0;
      epoch++;
      p0   = '{-100, -100};
      dend = '{-100, -100};
      q_a.delete();
      q_b.delete();
   endtask

   initial begin
      logic [15:0] v;
      int          n;
      repeat (5) @(negedge clk);
      rstn = 1'b1;
      repeat (100) @(negedge clk);

      // Single short message
      strobe(0, 160'hA53C);
      wait_idle(0, 400);
      repeat (3) @(negedge clk);

      // Strobe while busy is ignored
      strobe(0, 160'hA53C);
      repeat (49) @(negedge clk);
      strobe(0, 160'hFFFF);
      wait_idle(0, 400);
      repeat (3) @(negedge clk);

      // Strobe during the tx_done cycle is dropped, the next cycle is accepted
      strobe(0, 160'h1234);
      n = 0;
      while (cyc != dend[0] - 1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         checks++;
         errors++;
         $display("FAIL b2b_wait: no tx_done window within %0d cycles", n);
      end
      strobe(0, 160'hEEEE);
      strobe(0, 160'h0102);
      wait_idle(0, 400);
      repeat (3) @(negedge clk);

      // Reset in the DATA phase of byte 1
      strobe(0, 160'hBEEF);
      repeat (140) @(negedge clk);
      #2;
      do_reset();
      #1;
      chk("rst_line", 64'(line[0]), 64'd1);
      chk("rst_busy", 64'(bsy[0]), 64'd0);
      repeat (5) @(negedge clk);
      rstn = 1'b1;
      repeat (150) @(negedge clk);
      strobe(0, 160'h55AA);
      wait_idle(0, 400);

      // Random strobes with random gaps, some landing while busy
      for (int t = 0; t < 8; t++) begin
         v = 16'($urandom);
         strobe(0, {144'd0, v});
         repeat ($urandom_range(0, 260)) @(negedge clk);
      end
      wait_idle(0, 400);
      repeat (3) @(negedge clk);

      // 20-byte digest of SHA-1("abc")
      strobe(1, 160'hA9993E364706816ABA3E25717850C26C9CD0D89D);
      wait_idle(1, 12000);
      repeat (10) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
